multicycle_ctrl: RTL and testbench

Multicycle control FSM that sequences the 16-bit MIPS-style datapath. Drives every datapath control input, one phase per cycle: fetch, decode, execute, memory, writeback. Handshakes with a shared instruction/data memory port (memReq/memReady) and enforces a bus-timeout fault. Reports halt, illegal-instruction and bus-fault status, and counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the 16-bit MIPS-style datapath.
// Sequences fetch/decode/execute/memory/writeback one phase per cycle, handshakes
// with the shared memory port, faults on a stalled bus and counts retired instructions.
module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [15:0]            instruction,
    input  logic                   zero,
    input  logic                   memReady,
    output logic                   regWrite,
    output logic [1:0]             regDst,
    output logic [1:0]             memToReg,
    output logic [1:0]             jump,
    output logic [1:0]             aluSrc,
    output logic                   pcSrc,
    output logic [2:0]             aluCtrl,
    output logic                   irWrite,
    output logic                   pcEn,
    output logic                   memReq,
    output logic                   memWe,
    output logic                   halted,
    output logic                   illegal,
    output logic                   busErr,
    output logic [COUNT_WIDTH-1:0] instrCount
);

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_LW   = 4'h2;
    localparam logic [3:0] OP_SW   = 4'h3;
    localparam logic [3:0] OP_BEQ  = 4'h4;
    localparam logic [3:0] OP_J    = 4'h5;
    localparam logic [3:0] OP_JAL  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Last wait-counter value at which a still-missing memReady becomes a fault.
    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ILLEGAL, S_FAULT
    } state_t;

    state_t                 r_state;
    logic [15:0]            r_wait;
    logic [COUNT_WIDTH-1:0] r_count;

    logic [3:0] w_op;
    logic [2:0] w_funct;
    logic       w_legal;
    logic       w_timeout;
    logic       w_unused_fields;

    assign w_op            = instruction[15:12];
    assign w_funct         = instruction[2:0];
    assign w_unused_fields = ^instruction[11:3];
    // Only opcodes 0..6 are executable; R-type additionally needs funct 0..4.
    assign w_legal   = (w_op <= OP_JAL) && ((w_op != OP_R) || (w_funct <= 3'd4));
    // Raised on the last permitted stall cycle; a same-cycle memReady wins.
    assign w_timeout = (r_state == S_FETCH || r_state == S_MEM) && !memReady
                       && (r_wait == WAIT_LAST);

    // State sequencing, bus-wait counter and retire counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_wait  <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_FETCH, S_MEM: begin
                    if (memReady) begin
                        r_wait <= '0;
                        if (r_state == S_FETCH) begin
                            r_state <= S_DECODE;
                        end else if (w_op == OP_LW) begin
                            r_state <= S_WB;
                        end else begin
                            r_state <= S_FETCH;
                            r_count <= r_count + COUNT_WIDTH'(1);
                        end
                    end else if (w_timeout) begin
                        r_state <= S_FAULT;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
                S_DECODE: begin
                    if (w_op == OP_HALT)  r_state <= S_HALT;
                    else if (!w_legal)    r_state <= S_ILLEGAL;
                    else                  r_state <= S_EXEC;
                end
                S_EXEC: begin
                    r_wait <= '0;
                    case (w_op)
                        OP_R, OP_ADDI: r_state <= S_WB;
                        OP_LW, OP_SW:  r_state <= S_MEM;
                        default: begin
                            r_state <= S_FETCH;
                            r_count <= r_count + COUNT_WIDTH'(1);
                        end
                    endcase
                end
                S_WB: begin
                    r_wait  <= '0;
                    r_state <= S_FETCH;
                    r_count <= r_count + COUNT_WIDTH'(1);
                end
                default: r_state <= r_state;
            endcase
        end
    end

    // Control decode from the current phase and the instruction; silent while reset is held.
    always_comb begin
        regWrite = 1'b0;
        regDst   = 2'b00;
        memToReg = 2'b00;
        jump     = 2'b00;
        aluSrc   = 2'b00;
        pcSrc    = 1'b0;
        aluCtrl  = 3'b000;
        irWrite  = 1'b0;
        pcEn     = 1'b0;
        memReq   = 1'b0;
        memWe    = 1'b0;
        halted   = 1'b0;
        illegal  = 1'b0;
        busErr   = 1'b0;
        if (reset) begin
            aluCtrl = 3'b010;
            case (r_state)
                S_FETCH: begin
                    memReq  = 1'b1;
                    irWrite = memReady;
                    pcEn    = memReady;
                end
                S_EXEC: begin
                    case (w_op)
                        OP_R: begin
                            case (w_funct)
                                3'd1:    aluCtrl = 3'b110;
                                3'd2:    aluCtrl = 3'b000;
                                3'd3:    aluCtrl = 3'b001;
                                3'd4:    aluCtrl = 3'b111;
                                default: aluCtrl = 3'b010;
                            endcase
                        end
                        OP_ADDI, OP_LW, OP_SW: aluSrc = 2'b01;
                        OP_BEQ: begin
                            aluCtrl = 3'b110;
                            pcSrc   = 1'b1;
                            pcEn    = zero;
                        end
                        OP_J: begin
                            jump = 2'b01;
                            pcEn = 1'b1;
                        end
                        OP_JAL: begin
                            jump     = 2'b01;
                            pcEn     = 1'b1;
                            regWrite = 1'b1;
                            regDst   = 2'b10;
                            memToReg = 2'b10;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    // Keep the EXEC address path so the memory address stays stable.
                    memReq = 1'b1;
                    memWe  = (w_op == OP_SW);
                    aluSrc = 2'b01;
                end
                S_WB: begin
                    regWrite = 1'b1;
                    regDst   = (w_op == OP_R)  ? 2'b01 : 2'b00;
                    memToReg = (w_op == OP_LW) ? 2'b01 : 2'b00;
                end
                S_HALT:    halted  = 1'b1;
                S_ILLEGAL: illegal = 1'b1;
                S_FAULT:   busErr  = 1'b1;
                default: ;
            endcase
        end
    end

    assign instrCount = r_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed literal checks, then randomized instructions,
// memory stalls and resets compared every cycle against a phase-sequence model.
module tb_multicycle_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    localparam int PF = 0, PD = 1, PE = 2, PM = 3, PW = 4;
    localparam int T_NONE = 0, T_HALT = 1, T_ILL = 2, T_FAULT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   instruction;
    logic          zero;
    logic          memReady;
    logic          regWrite, pcSrc, irWrite, pcEn, memReq, memWe;
    logic          halted, illegal, busErr;
    logic [1:0]    regDst, memToReg, jump, aluSrc;
    logic [2:0]    aluCtrl;
    logic [CW-1:0] instrCount;

    int n_checks = 0;
    int n_fail   = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .zero(zero),
        .memReady(memReady), .regWrite(regWrite), .regDst(regDst),
        .memToReg(memToReg), .jump(jump), .aluSrc(aluSrc), .pcSrc(pcSrc),
        .aluCtrl(aluCtrl), .irWrite(irWrite), .pcEn(pcEn), .memReq(memReq),
        .memWe(memWe), .halted(halted), .illegal(illegal), .busErr(busErr),
        .instrCount(instrCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An instruction is a fixed list of phases chosen by its opcode; the model
    // walks an index through that list, stalling on memory phases.
    function automatic int seq_len(input logic [3:0] op);
        case (op)
            4'h0, 4'h1, 4'h3: return 4;
            4'h2:             return 5;
            default:          return 3;
        endcase
    endfunction

    function automatic int phase_at(input logic [3:0] op, input int idx);
        case (idx)
            0: return PF;
            1: return PD;
            2: return PE;
            3: return (op == 4'h2 || op == 4'h3) ? PM : PW;
            default: return PW;
        endcase
    endfunction

    function automatic bit is_legal(input logic [15:0] ins);
        return (ins[15:12] <= 4'h6) && (ins[15:12] != 4'h0 || ins[2:0] <= 3'd4);
    endfunction

    bit m_valid = 0;
    int m_idx = 0, m_term = 0, m_wait = 0, m_count = 0;

    always @(posedge clk) begin
        int ph;
        if (!reset) begin
            m_valid <= 1;
            m_idx   <= 0;
            m_term  <= T_NONE;
            m_wait  <= 0;
            m_count <= 0;
        end else if (m_valid && m_term == T_NONE) begin
            ph = phase_at(instruction[15:12], m_idx);
            if ((ph == PF || ph == PM) && !memReady) begin
                if (m_wait == TO - 1) m_term <= T_FAULT;
                else                  m_wait <= m_wait + 1;
            end else if (ph == PD && instruction[15:12] == 4'hF) begin
                m_term <= T_HALT;
            end else if (ph == PD && !is_legal(instruction)) begin
                m_term <= T_ILL;
            end else begin
                m_wait <= 0;
                if (m_idx + 1 == seq_len(instruction[15:12])) begin
                    m_idx   <= 0;
                    m_count <= (m_count + 1) % (1 << CW);
                end else begin
                    m_idx <= m_idx + 1;
                end
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        int ph, op, fn;
        int e_rw, e_rd, e_m2r, e_j, e_as, e_ps, e_alu, e_ir, e_pe, e_mr, e_mw, e_h, e_i, e_b;
        int alu_tab[5] = '{2, 6, 0, 1, 7};
        if (m_valid) begin
            op = int'(instruction[15:12]);
            fn = int'(instruction[2:0]);
            ph = phase_at(instruction[15:12], m_idx);
            {e_rw, e_rd, e_m2r, e_j, e_as, e_ps, e_ir, e_pe, e_mr, e_mw} = '0;
            e_alu = 2;
            e_h = (m_term == T_HALT);
            e_i = (m_term == T_ILL);
            e_b = (m_term == T_FAULT);
            if (!reset) begin
                e_h = 0; e_i = 0; e_b = 0;
            end else if (m_term == T_NONE) begin
                if (ph == PF) begin
                    e_mr = 1; e_ir = memReady; e_pe = memReady;
                end else if (ph == PE) begin
                    if (op == 0) e_alu = (fn < 5) ? alu_tab[fn] : 2;
                    else if (op >= 1 && op <= 3) e_as = 1;
                    else if (op == 4) begin e_alu = 6; e_ps = 1; e_pe = zero; end
                    else begin
                        e_j = 1; e_pe = 1;
                        if (op == 6) begin e_rw = 1; e_rd = 2; e_m2r = 2; end
                    end
                end else if (ph == PM) begin
                    e_mr = 1; e_mw = (op == 3); e_as = 1;
                end else if (ph == PW) begin
                    e_rw = 1; e_rd = (op == 0) ? 1 : 0; e_m2r = (op == 2) ? 1 : 0;
                end
            end
            check("regWrite", regWrite, e_rw);
            check("regDst", regDst, e_rd);
            check("memToReg", memToReg, e_m2r);
            check("jump", jump, e_j);
            check("aluSrc", aluSrc, e_as);
            check("pcSrc", pcSrc, e_ps);
            if (reset) check("aluCtrl", aluCtrl, e_alu);
            check("irWrite", irWrite, e_ir);
            check("pcEn", pcEn, e_pe);
            check("memReq", memReq, e_mr);
            check("memWe", memWe, e_mw);
            check("halted", halted, e_h);
            check("illegal", illegal, e_i);
            check("busErr", busErr, e_b);
            check("instrCount", instrCount, m_count);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [15:0] gen_instr();
        int r;
        logic [15:0] v;
        r = $urandom_range(0, 99);
        v = 16'($urandom);
        if (r < 2)      v[15:12] = 4'(7 + $urandom_range(0, 7));
        else if (r < 4) v[15:12] = 4'hF;
        else if (r < 6) begin v[15:12] = 4'h0; v[2:0] = 3'(5 + $urandom_range(0, 2)); end
        else begin
            v[15:12] = 4'($urandom_range(0, 6));
            if (v[15:12] == 4'h0) v[2:0] = 3'($urandom_range(0, 4));
        end
        return v;
    endfunction

    initial begin
        int term_cycles, rst_left;
        reset = 1'b0; memReady = 1'b1; zero = 1'b0; instruction = 16'h0000;

        // Reset held two cycles: everything quiet, counter cleared.
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", instrCount, 0);
        check("rst_memReq", memReq, 0);
        check("rst_regWrite", regWrite, 0);

        // add r3,r1,r2 with an immediately ready memory.
        reset = 1'b1; instruction = 16'h0298;
        #1;
        check("add_F_memReq", memReq, 1);
        check("add_F_irWrite", irWrite, 1);
        check("add_F_pcEn", pcEn, 1);
        @(posedge clk);
        @(posedge clk); #1;
        check("add_E_aluCtrl", aluCtrl, 3'b010);
        check("add_E_aluSrc", aluSrc, 0);
        @(posedge clk); #1;
        check("add_W_regWrite", regWrite, 1);
        check("add_W_regDst", regDst, 2'b01);
        check("add_W_count", instrCount, 0);
        @(posedge clk); #1;
        check("add_retired", instrCount, 1);

        // beq taken: branch select and PC enable in EXEC, retire after 3 cycles.
        instruction = 16'h4280; zero = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        check("beq_pcSrc", pcSrc, 1);
        check("beq_pcEn", pcEn, 1);
        check("beq_aluCtrl", aluCtrl, 3'b110);
        @(posedge clk); #1;
        check("beq_retired", instrCount, 2);

        // Undefined opcode is terminal and does not retire.
        instruction = 16'h7000;
        @(posedge clk);
        @(posedge clk); #1;
        check("ill_flag", illegal, 1);
        check("ill_memReq", memReq, 0);
        check("ill_count", instrCount, 2);
        reset = 1'b0;
        @(posedge clk); #1;
        check("ill_cleared", illegal, 0);

        // Fetch stalled: fault after exactly TO wait cycles.
        reset = 1'b1; memReady = 1'b0; instruction = 16'h1041;
        repeat (TO - 1) @(posedge clk);
        #1;
        check("to_not_yet", busErr, 0);
        @(posedge clk); #1;
        check("to_fault", busErr, 1);
        check("to_memReq", memReq, 0);

        // Ready arriving on the last permitted cycle completes normally.
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (TO - 1) @(posedge clk);
        #1;
        memReady = 1'b1;
        @(posedge clk); #1;
        check("to_rescue_busErr", busErr, 0);
        check("to_rescue_decode_memReq", memReq, 0);

        // Randomized run.
        term_cycles = 0; rst_left = 0;
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #1;
            term_cycles = (m_term != T_NONE) ? term_cycles + 1 : 0;
            if (rst_left == 0 && (term_cycles >= 3 || $urandom_range(0, 299) == 0))
                rst_left = 1 + $urandom_range(0, 1);
            if (rst_left > 0) begin
                reset = 1'b0;
                rst_left--;
            end else begin
                reset = 1'b1;
            end
            memReady = ($urandom_range(0, 9) < 7);
            zero     = 1'($urandom);
            if (m_idx == 0 && m_term == T_NONE) instruction = gen_instr();
        end

        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
